// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci-code segment splitter and decoder.
// State encoding and error-tag bit positions live here so both blocks agree.
package fib_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_FIN  = 2'd3
    } fib_state_e;

    localparam int ERR_W       = 2;
    localparam int ERR_OVF     = 0;
    localparam int ERR_NODELIM = 1;

endpackage

// File: rtl/fib_seg_acc.sv
// Segment accumulator: bits are pushed in scan order into seg[0], seg[1], ...
// Length saturates at W_OUT; further pushes only raise the overflow flag.
module fib_seg_acc #(
    parameter int W_OUT = 32,
    parameter int LEN_W = $clog2(W_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             bit_i,
    output logic [W_OUT-1:0] seg_o,
    output logic [LEN_W-1:0] len_o,
    output logic             ovf_o
);

    logic [W_OUT-1:0] seg_q, seg_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        seg_d = seg_q;
        len_d = len_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            seg_d = '0;
            len_d = '0;
            ovf_d = 1'b0;
        end else if (push_i) begin
            if (len_q < LEN_W'(W_OUT)) begin
                for (int i = 0; i < W_OUT; i++) begin
                    if (LEN_W'(i) == len_q) seg_d[i] = bit_i;
                end
                len_d = len_q + LEN_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q <= '0;
            len_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            seg_q <= seg_d;
            len_q <= len_d;
            ovf_q <= ovf_d;
        end
    end

    assign seg_o = seg_q;
    assign len_o = len_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/fib_seg_splitter.sv
// Splits one word of concatenated Fibonacci codewords into up to N_SEG
// segments, one scanned bit per cycle, using a delimiter mask.
module fib_seg_splitter
    import fib_pkg::*;
#(
    parameter int W_IN      = 64,
    parameter int W_OUT     = 32,
    parameter int N_SEG     = 3,
    parameter int MSB_FIRST = 0,
    localparam int LEN_W    = $clog2(W_OUT + 1),
    localparam int IDX_W    = $clog2(N_SEG),
    localparam int PTR_W    = $clog2(W_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in_data,
    input  logic [W_IN-1:0]  in_mark,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_OUT-1:0] out_data,
    output logic [LEN_W-1:0] out_len,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic [ERR_W-1:0] out_err,
    output logic             done,
    output logic             busy,
    output logic [1:0]       dbg_state_o
);

    localparam logic [PTR_W-1:0] PTR_START = (MSB_FIRST != 0) ? PTR_W'(W_IN - 1) : '0;
    localparam logic [PTR_W-1:0] PTR_FINAL = (MSB_FIRST != 0) ? '0 : PTR_W'(W_IN - 1);

    fib_state_e       state_q, state_d;
    logic [W_IN-1:0]  data_q, data_d;
    logic [W_IN-1:0]  mark_q, mark_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_step;
    logic [IDX_W-1:0] seg_cnt_q, seg_cnt_d;
    logic             last_q, last_d;
    logic             nodelim_q, nodelim_d;
    logic             acc_clear, acc_push, acc_ovf;
    logic             cur_mark, at_final;

    assign cur_mark    = mark_q[rd_ptr_q];
    assign at_final    = (rd_ptr_q == PTR_FINAL);
    assign rd_ptr_step = (MSB_FIRST != 0) ? rd_ptr_q - PTR_W'(1) : rd_ptr_q + PTR_W'(1);

    fib_seg_acc #(.W_OUT(W_OUT), .LEN_W(LEN_W)) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clear_i (acc_clear),
        .push_i  (acc_push),
        .bit_i   (data_q[rd_ptr_q]),
        .seg_o   (out_data),
        .len_o   (out_len),
        .ovf_o   (acc_ovf)
    );

    // Both streams: a transfer happens on a rising edge where valid && ready;
    // out_* hold steady while out_valid is high and out_ready is low.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        mark_d    = mark_q;
        rd_ptr_d  = rd_ptr_q;
        seg_cnt_d = seg_cnt_q;
        last_d    = last_q;
        nodelim_d = nodelim_q;
        acc_clear = 1'b0;
        acc_push  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d    = in_data;
                    mark_d    = in_mark;
                    rd_ptr_d  = PTR_START;
                    seg_cnt_d = '0;
                    last_d    = 1'b0;
                    nodelim_d = 1'b0;
                    acc_clear = 1'b1;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                acc_push = 1'b1;
                if (cur_mark || at_final) begin
                    last_d    = (seg_cnt_q == IDX_W'(N_SEG - 1)) || at_final;
                    nodelim_d = ~cur_mark;
                    state_d   = ST_EMIT;
                end else begin
                    rd_ptr_d = rd_ptr_step;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = ST_FIN;
                    end else begin
                        acc_clear = 1'b1;
                        seg_cnt_d = seg_cnt_q + IDX_W'(1);
                        rd_ptr_d  = rd_ptr_step;
                        last_d    = 1'b0;
                        nodelim_d = 1'b0;
                        state_d   = ST_SCAN;
                    end
                end
            end
            ST_FIN: begin
                acc_clear = 1'b1;
                seg_cnt_d = '0;
                last_d    = 1'b0;
                nodelim_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            mark_q    <= '0;
            rd_ptr_q  <= '0;
            seg_cnt_q <= '0;
            last_q    <= 1'b0;
            nodelim_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            mark_q    <= mark_d;
            rd_ptr_q  <= rd_ptr_d;
            seg_cnt_q <= seg_cnt_d;
            last_q    <= last_d;
            nodelim_q <= nodelim_d;
        end
    end

    assign in_ready             = (state_q == ST_IDLE);
    assign out_valid            = (state_q == ST_EMIT);
    assign out_idx              = seg_cnt_q;
    assign out_last             = last_q;
    assign out_err[ERR_OVF]     = acc_ovf;
    assign out_err[ERR_NODELIM] = nodelim_q;
    assign done                 = (state_q == ST_FIN);
    assign busy                 = (state_q != ST_IDLE);
    assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_fib_seg_splitter.sv
// Directed bench for fib_seg_splitter at W_IN=16, W_OUT=8, N_SEG=3, plus an
// MSB_FIRST=1 instance for the reverse scan direction.
module tb_fib_seg_splitter;

    logic        clk;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_data, in_mark;
    logic [7:0]  out_data;
    logic [3:0]  out_len;
    logic [1:0]  out_idx;
    logic        out_last;
    logic [1:0]  out_err;
    logic        done, busy;
    logic [1:0]  dbg_state;

    logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready;
    logic [15:0] m_in_data, m_in_mark;
    logic [7:0]  m_out_data;
    logic [3:0]  m_out_len;
    logic [1:0]  m_out_idx;
    logic        m_out_last;
    logic [1:0]  m_out_err;
    logic        m_done, m_busy;
    logic [1:0]  m_dbg_state;

    int n_cmp;
    int n_fail;

    fib_seg_splitter #(.W_IN(16), .W_OUT(8), .N_SEG(3), .MSB_FIRST(0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mark(in_mark),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_len(out_len), .out_idx(out_idx), .out_last(out_last), .out_err(out_err),
        .done(done), .busy(busy), .dbg_state_o(dbg_state)
    );

    fib_seg_splitter #(.W_IN(16), .W_OUT(8), .N_SEG(3), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data), .in_mark(m_in_mark),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data),
        .out_len(m_out_len), .out_idx(m_out_idx), .out_last(m_out_last), .out_err(m_out_err),
        .done(m_done), .busy(m_busy), .dbg_state_o(m_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // segment fields packed as {data, len, idx, last, err}
    function automatic logic [16:0] seg_now();
        return {out_data, out_len, out_idx, out_last, out_err};
    endfunction

    function automatic logic [16:0] seg_now_m();
        return {m_out_data, m_out_len, m_out_idx, m_out_last, m_out_err};
    endfunction

    // bounded wait for out_valid; returns cycles waited (60 on timeout)
    task automatic wait_valid(input bit sel, output int n);
        n = 0;
        while (((sel ? m_out_valid : out_valid) !== 1'b1) && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({out_valid, out_data, out_len, out_idx, out_last, out_err, done, busy, in_ready, dbg_state}
            !== {1'b0, 8'h00, 4'd0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_in: got v=%b d=%h l=%0d i=%0d last=%b e=%b done=%b busy=%b rdy=%b st=%0d want all 0, rdy=1",
                     out_valid, out_data, out_len, out_idx, out_last, out_err, done, busy, in_ready, dbg_state);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({out_valid, done, busy, in_ready, m_in_ready} !== 5'b00011) begin
            n_fail++;
            $display("FAIL reset_out: got %b want 00011", {out_valid, done, busy, in_ready, m_in_ready});
        end
    endtask

    task automatic test_basic();
        int n;
        logic [16:0] exp_seg[3];
        int exp_lat[3];
        exp_seg = '{{8'h05, 4'd3, 2'd0, 1'b0, 2'b00},
                    {8'h04, 4'd3, 2'd1, 1'b0, 2'b00},
                    {8'h0C, 4'd4, 2'd2, 1'b1, 2'b00}};
        exp_lat = '{3, 3, 4};
        out_ready = 1'b1;
        in_data   = 16'h0325;
        in_mark   = 16'h0224;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            wait_valid(1'b0, n);
            n_cmp++;
            if (n !== exp_lat[s]) begin
                n_fail++;
                $display("FAIL basic_lat%0d: got %0d want %0d", s, n, exp_lat[s]);
            end
            n_cmp++;
            if (seg_now() !== exp_seg[s]) begin
                n_fail++;
                $display("FAIL basic_seg%0d: got %h want %h", s, seg_now(), exp_seg[s]);
            end
            tick();
        end
        n_cmp++;
        if ({done, busy, in_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL basic_done: got %b want 110", {done, busy, in_ready});
        end
        tick();
        n_cmp++;
        if ({done, busy, in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL basic_idle: got %b want 001", {done, busy, in_ready});
        end
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        in_data   = 16'h0325;
        in_mark   = 16'h0224;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(1'b0, n);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({out_valid, seg_now()} !== {1'b1, 8'h05, 4'd3, 2'd0, 1'b0, 2'b00}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got %h want %h", i, {out_valid, seg_now()},
                         {1'b1, 8'h05, 4'd3, 2'd0, 1'b0, 2'b00});
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        wait_valid(1'b0, n);
        n_cmp++;
        if (n + 1 !== 4) begin
            n_fail++;
            $display("FAIL bp_seg1_lat: got %0d want 4", n + 1);
        end
        n_cmp++;
        if (seg_now() !== {8'h04, 4'd3, 2'd1, 1'b0, 2'b00}) begin
            n_fail++;
            $display("FAIL bp_seg1: got %h want %h", seg_now(), {8'h04, 4'd3, 2'd1, 1'b0, 2'b00});
        end
        tick();
        wait_valid(1'b0, n);
        tick();
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_idle: got %b want 1", in_ready);
        end
    endtask

    task automatic test_overflow();
        int n;
        out_ready = 1'b1;
        in_data   = 16'hFFFF;
        in_mark   = 16'h0800;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(1'b0, n);
        n_cmp++;
        if (n !== 12) begin
            n_fail++;
            $display("FAIL ovf_lat0: got %0d want 12", n);
        end
        n_cmp++;
        if (seg_now() !== {8'hFF, 4'd8, 2'd0, 1'b0, 2'b01}) begin
            n_fail++;
            $display("FAIL ovf_seg0: got %h want %h", seg_now(), {8'hFF, 4'd8, 2'd0, 1'b0, 2'b01});
        end
        tick();
        wait_valid(1'b0, n);
        n_cmp++;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL ovf_lat1: got %0d want 4", n);
        end
        n_cmp++;
        if (seg_now() !== {8'h0F, 4'd4, 2'd1, 1'b1, 2'b10}) begin
            n_fail++;
            $display("FAIL ovf_seg1: got %h want %h", seg_now(), {8'h0F, 4'd4, 2'd1, 1'b1, 2'b10});
        end
        tick();
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_done: got %b want 1", done);
        end
        tick();
    endtask

    task automatic test_nodelim();
        int n;
        out_ready = 1'b1;
        in_data   = 16'h00A5;
        in_mark   = 16'h0000;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(1'b0, n);
        n_cmp++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL nodelim_lat: got %0d want 16", n);
        end
        n_cmp++;
        if (seg_now() !== {8'hA5, 4'd8, 2'd0, 1'b1, 2'b11}) begin
            n_fail++;
            $display("FAIL nodelim_seg: got %h want %h", seg_now(), {8'hA5, 4'd8, 2'd0, 1'b1, 2'b11});
        end
        tick();
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL nodelim_done: got %b want 1", done);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        out_ready = 1'b1;
        in_data   = 16'h0325;
        in_mark   = 16'h0224;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(1'b0, n);
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_data, out_len, out_idx, out_last, out_err, done, busy, in_ready}
            !== {1'b0, 8'h00, 4'd0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rstmid_outs: got %h want %h",
                     {out_valid, out_data, out_len, out_idx, out_last, out_err, done, busy, in_ready},
                     {1'b0, 8'h00, 4'd0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1});
        end
        tick();
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(1'b0, n);
        n_cmp++;
        if (n !== 3 || seg_now() !== {8'h05, 4'd3, 2'd0, 1'b0, 2'b00}) begin
            n_fail++;
            $display("FAIL rstmid_seg0: got lat %0d seg %h want lat 3 seg %h", n, seg_now(),
                     {8'h05, 4'd3, 2'd0, 1'b0, 2'b00});
        end
        n = 0;
        while (in_ready !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_drain: got in_ready %b want 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        out_ready = 1'b1;
        in_data   = 16'h0325;
        in_mark   = 16'h0224;
        in_valid  = 1'b1;
        tick();
        in_data = 16'h00A5;
        in_mark = 16'h0000;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy_rdy: got %b want 0", in_ready);
        end
        wait_valid(1'b0, n);
        n_cmp++;
        if (seg_now() !== {8'h05, 4'd3, 2'd0, 1'b0, 2'b00}) begin
            n_fail++;
            $display("FAIL b2b_a_seg0: got %h want %h", seg_now(), {8'h05, 4'd3, 2'd0, 1'b0, 2'b00});
        end
        tick();
        wait_valid(1'b0, n);
        tick();
        wait_valid(1'b0, n);
        n_cmp++;
        if (seg_now() !== {8'h0C, 4'd4, 2'd2, 1'b1, 2'b00}) begin
            n_fail++;
            $display("FAIL b2b_a_seg2: got %h want %h", seg_now(), {8'h0C, 4'd4, 2'd2, 1'b1, 2'b00});
        end
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        wait_valid(1'b0, n);
        n_cmp++;
        if (n !== 16 || seg_now() !== {8'hA5, 4'd8, 2'd0, 1'b1, 2'b11}) begin
            n_fail++;
            $display("FAIL b2b_b_seg: got lat %0d seg %h want lat 16 seg %h", n, seg_now(),
                     {8'hA5, 4'd8, 2'd0, 1'b1, 2'b11});
        end
        tick();
        tick();
    endtask

    task automatic test_msb_first();
        int n;
        m_out_ready = 1'b1;
        m_in_data   = 16'h8000;
        m_in_mark   = 16'h8000;
        m_in_valid  = 1'b1;
        tick();
        m_in_valid = 1'b0;
        wait_valid(1'b1, n);
        n_cmp++;
        if (n !== 1 || seg_now_m() !== {8'h01, 4'd1, 2'd0, 1'b0, 2'b00}) begin
            n_fail++;
            $display("FAIL msb_seg0: got lat %0d seg %h want lat 1 seg %h", n, seg_now_m(),
                     {8'h01, 4'd1, 2'd0, 1'b0, 2'b00});
        end
        tick();
        wait_valid(1'b1, n);
        n_cmp++;
        if (n !== 15 || seg_now_m() !== {8'h00, 4'd8, 2'd1, 1'b1, 2'b11}) begin
            n_fail++;
            $display("FAIL msb_seg1: got lat %0d seg %h want lat 15 seg %h", n, seg_now_m(),
                     {8'h00, 4'd8, 2'd1, 1'b1, 2'b11});
        end
        tick();
        n_cmp++;
        if (m_done !== 1'b1) begin
            n_fail++;
            $display("FAIL msb_done: got %b want 1", m_done);
        end
        tick();
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_mark     = '0;
        out_ready   = 1'b0;
        m_in_valid  = 1'b0;
        m_in_data   = '0;
        m_in_mark   = '0;
        m_out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_nodelim();
        test_reset_mid();
        test_back_to_back();
        test_msb_first();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
